// File: rtl/resolved_branch_bht.sv
// resolved_branch_bht
//   Branch history table of 2-bit saturating counters. The table is trained
//   from the execute-stage resolve bus and gives the frontend a registered
//   taken/not-taken prediction for a looked-up PC.
//
//   clk_i / rst_ni        clock, asynchronous active-low reset
//   flush_bp_i            restart the table clear sequence from entry 0
//   debug_mode_i          blocks training
//   resolved_*            resolve bus: valid, pc, is_branch, taken
//   lookup_valid_i/vpc_i  prediction request
//   pred_valid_o          request accepted in the previous cycle
//   pred_taken_o          counter MSB for the requested PC (held when idle)
//   ready_o               table initialised, lookups/updates accepted
module resolved_branch_bht #(
  parameter int unsigned VLEN       = 39,
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned RVC        = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            resolved_valid_i,
  input  logic [VLEN-1:0] resolved_pc_i,
  input  logic            resolved_is_branch_i,
  input  logic            resolved_taken_i,
  input  logic            lookup_valid_i,
  input  logic [VLEN-1:0] lookup_vpc_i,
  output logic            pred_valid_o,
  output logic            pred_taken_o,
  output logic            ready_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam int unsigned OFS   = (RVC != 0) ? 1 : 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  // Counter storage has no reset: the CLEAR sequence initialises it after
  // every reset or flush.
  logic [1:0] ctr_q [NR_ENTRIES];

  logic [IDX_W-1:0] upd_idx, lk_idx, mem_widx;
  logic [1:0]       upd_cur, upd_ctr, lk_ctr, mem_wdata;
  logic             run, upd_en, lk_en, mem_we;
  logic             pred_valid_q, pred_taken_q, ready_q;

  assign upd_idx = resolved_pc_i[OFS +: IDX_W];
  assign lk_idx  = lookup_vpc_i[OFS +: IDX_W];
  assign run     = (state_q == RUN);

  assign upd_en = run & ~flush_bp_i & resolved_valid_i & resolved_is_branch_i
                & ~debug_mode_i;
  assign lk_en  = run & ~flush_bp_i & lookup_valid_i;

  always_comb begin
    upd_cur = ctr_q[upd_idx];
    upd_ctr = upd_cur;
    if (resolved_taken_i) begin
      if (upd_cur != 2'd3) upd_ctr = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'd0) upd_ctr = upd_cur - 2'd1;
    end
  end

  // Write-first bypass: a same-cycle update to the looked-up entry wins.
  always_comb begin
    lk_ctr = ctr_q[lk_idx];
    if (upd_en && (upd_idx == lk_idx)) lk_ctr = upd_ctr;
  end

  // Single write port shared by the clear sequence and training.
  always_comb begin
    mem_we    = upd_en;
    mem_widx  = upd_idx;
    mem_wdata = upd_ctr;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = clr_idx_q;
      mem_wdata = 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) ctr_q[mem_widx] <= mem_wdata;
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == LAST_IDX) state_d = RUN;
    end
    if (flush_bp_i) begin
      state_d   = CLEAR;
      clr_idx_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      pred_valid_q <= lk_en;
      if (lk_en) pred_taken_q <= lk_ctr[1];
      ready_q      <= (state_d == RUN);
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign ready_o      = ready_q;

endmodule

// File: tb/tb_resolved_branch_bht.sv
// Directed bench for resolved_branch_bht (VLEN=39, NR_ENTRIES=1024, RVC=1).
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_resolved_branch_bht;

  localparam int VLEN = 39;
  localparam int NR   = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, dbg;
  logic            res_valid, res_is_branch, res_taken;
  logic [VLEN-1:0] res_pc;
  logic            lk_valid;
  logic [VLEN-1:0] lk_vpc;
  logic            pred_valid, pred_taken, ready;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  resolved_branch_bht #(.VLEN(VLEN), .NR_ENTRIES(NR), .RVC(1)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_bp_i          (flush),
    .debug_mode_i        (dbg),
    .resolved_valid_i    (res_valid),
    .resolved_pc_i       (res_pc),
    .resolved_is_branch_i(res_is_branch),
    .resolved_taken_i    (res_taken),
    .lookup_valid_i      (lk_valid),
    .lookup_vpc_i        (lk_vpc),
    .pred_valid_o        (pred_valid),
    .pred_taken_o        (pred_taken),
    .ready_o             (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; dbg = 0; res_valid = 0; res_is_branch = 0; res_taken = 0;
    res_pc = '0; lk_valid = 0; lk_vpc = '0;
  endtask

  // One clock with the given inputs; returns 1ns after the edge.
  task automatic step(input logic rv, input logic [VLEN-1:0] rpc, input logic br,
                      input logic tk, input logic d, input logic lv,
                      input logic [VLEN-1:0] lpc, input logic fl);
    res_valid = rv; res_pc = rpc; res_is_branch = br; res_taken = tk;
    dbg = d; lk_valid = lv; lk_vpc = lpc; flush = fl;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic upd(input logic [VLEN-1:0] pc, input logic tk);
    step(1, pc, 1, tk, 0, 0, '0, 0);
  endtask

  task automatic lookup(input string tag, input logic [VLEN-1:0] pc, input logic exp);
    step(0, '0, 0, 0, 0, 1, pc, 0);
    chk({tag, "_valid"}, 32'(pred_valid), 32'd1);
    chk({tag, "_taken"}, 32'(pred_taken), 32'(exp));
  endtask

  // Lookup every cycle while clearing; returns cycles until ready_o rises.
  task automatic wait_ready(input string tag, output int cyc);
    cyc = 0;
    forever begin
      step(0, '0, 0, 0, 0, 1, 39'h80, 0);
      cyc++;
      chk({tag, "_pvalid_clear"}, 32'(pred_valid), 32'd0);
      if (ready) break;
      if (cyc > 2 * NR) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'(NR));
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst_n = 1;

    // 1: clear length after reset
    wait_ready("init", cyc);
    chk("init_clear_cycles", 32'(cyc), 32'(NR));

    // 2: 01 -> 10 -> 11
    upd(39'h80, 1);
    upd(39'h80, 1);
    lookup("t2", 39'h80, 1);

    // 3: saturate at 3, then 2 (taken), then 1 (not taken)
    repeat (5) upd(39'h80, 1);
    upd(39'h80, 0);
    lookup("t3_ctr2", 39'h80, 1);
    upd(39'h80, 0);
    lookup("t3_ctr1", 39'h80, 0);

    // 4: bypass at 0x100 from ctr=1
    lookup("t4_pre", 39'h100, 0);
    step(1, 39'h100, 1, 1, 0, 1, 39'h100, 0);
    chk("t4_byp_valid", 32'(pred_valid), 32'd1);
    chk("t4_byp_taken", 32'(pred_taken), 32'd1);
    step(0, '0, 0, 0, 0, 0, '0, 0);
    chk("t4_idle_valid", 32'(pred_valid), 32'd0);
    chk("t4_idle_hold", 32'(pred_taken), 32'd1);

    // 5: blocked training at 0x200 (ctr=1)
    step(1, 39'h200, 1, 1, 1, 0, '0, 0);
    lookup("t5_debug", 39'h200, 0);
    step(1, 39'h200, 0, 1, 0, 0, '0, 0);
    lookup("t5_jump", 39'h200, 0);
    upd(39'h200, 1);
    lookup("t5_trained", 39'h200, 1);

    // 6: train 0x80 to 3, flush, re-flush at clear cycle 500
    upd(39'h80, 1);
    upd(39'h80, 1);
    lookup("t6_pre", 39'h80, 1);
    step(1, 39'h80, 1, 0, 0, 1, 39'h80, 1);
    chk("t6_flush_valid", 32'(pred_valid), 32'd0);
    chk("t6_flush_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 500; i++) begin
      step(0, '0, 0, 0, 0, 1, 39'h80, 0);
      chk("t6_clear_ready", 32'(ready), 32'd0);
    end
    step(0, '0, 0, 0, 0, 0, '0, 1);
    chk("t6_reflush_ready", 32'(ready), 32'd0);
    wait_ready("t6", cyc);
    chk("t6_clear_cycles", 32'(cyc), 32'(NR));
    lookup("t6_post", 39'h80, 0);
    lookup("t6_alias_pre", 39'h880, 0);
    upd(39'h880, 1);
    lookup("t6_alias", 39'h80, 1);

    // Reset mid-operation returns outputs to reset values immediately
    #2 rst_n = 0;
    #1;
    chk("mid_rst_pred_valid", 32'(pred_valid), 32'd0);
    chk("mid_rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
